// File: rtl/i2s_tx.sv
// I2S transmitter: one-frame holding register feeding a bclk/lrclk generator and
// an MSB-first serializer in standard I2S framing (one bclk delay after lrclk).
module i2s_tx #(
    parameter int DATA_WIDTH    = 18,
    parameter int SLOT_WIDTH    = 32,
    parameter int CLK_DIV       = 4,
    parameter int OFFSET_BIN_IN = 0
) (
    input  logic                  dclk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din_left,
    input  logic [DATA_WIDTH-1:0] din_right,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdout,
    output logic                  underrun
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(2*SLOT_WIDTH);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV-1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2*SLOT_WIDTH-1);
    localparam logic [BW-1:0] SLOT     = BW'(SLOT_WIDTH);
    localparam logic [BW-1:0] DLEN     = BW'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] FLIP =
        (OFFSET_BIN_IN != 0) ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : '0;

    logic [CW-1:0]         div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [BW-1:0]         bit_nxt;
    logic [BW-1:0]         pos;
    logic                  chan_nxt;
    logic                  data_slot;
    logic                  fall;
    logic                  frame_start;
    logic                  accept;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] hold_l, hold_r;
    logic [DATA_WIDTH-1:0] sh_l, sh_r;

    assign din_ready   = ~hold_full;
    assign accept      = din_valid & ~hold_full;
    assign fall        = (div_cnt == DIV_LAST) & bclk;
    assign bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
    assign chan_nxt    = (bit_nxt >= SLOT);
    assign pos         = chan_nxt ? bit_nxt - SLOT : bit_nxt;
    // Slot position 0 is the I2S one-bit delay; data occupies 1..DATA_WIDTH.
    assign data_slot   = (pos != '0) && (pos <= DLEN);
    assign frame_start = fall & (bit_nxt == '0);

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // Data and word select only move on bclk falling edges.
    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= BIT_LAST;
            lrclk    <= 1'b0;
            sdout    <= 1'b0;
            underrun <= 1'b0;
            sh_l     <= '0;
            sh_r     <= '0;
        end else begin
            underrun <= 1'b0;
            if (fall) begin
                bit_cnt <= bit_nxt;
                lrclk   <= chan_nxt;
                sdout   <= 1'b0;
                if (frame_start) begin
                    sh_l     <= hold_full ? hold_l : '0;
                    sh_r     <= hold_full ? hold_r : '0;
                    underrun <= ~hold_full;
                end else if (data_slot) begin
                    if (chan_nxt) begin
                        sdout <= sh_r[DATA_WIDTH-1];
                        sh_r  <= sh_r << 1;
                    end else begin
                        sdout <= sh_l[DATA_WIDTH-1];
                        sh_l  <= sh_l << 1;
                    end
                end
            end
        end
    end

    // Accept needs an empty register, so it never collides with the unload.
    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_l    <= din_left ^ FLIP;
            hold_r    <= din_right ^ FLIP;
        end else if (frame_start) begin
            hold_full <= 1'b0;
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: two instances (two's complement and offset binary) checked
// every dclk against an arithmetic frame/bit-position model.
module tb_i2s_tx;
    localparam int DW = 18;

    logic dclk = 1'b0;
    always #5 dclk = ~dclk;

    logic          rst0, rst1, valid0, valid1;
    logic [DW-1:0] din_left, din_right;
    logic          ready0, bclk0, lrclk0, sdout0, under0;
    logic          ready1, bclk1, lrclk1, sdout1, under1;

    i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(32), .CLK_DIV(4), .OFFSET_BIN_IN(0)) dut0 (
        .dclk(dclk), .rst(rst0), .din_left(din_left), .din_right(din_right),
        .din_valid(valid0), .din_ready(ready0), .bclk(bclk0), .lrclk(lrclk0),
        .sdout(sdout0), .underrun(under0));

    i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(32), .CLK_DIV(4), .OFFSET_BIN_IN(1)) dut1 (
        .dclk(dclk), .rst(rst1), .din_left(din_left), .din_right(din_right),
        .din_valid(valid1), .din_ready(ready1), .bclk(bclk1), .lrclk(lrclk1),
        .sdout(sdout1), .underrun(under1));

    int ncmp = 0;
    int nerr = 0;

    // Model state: n = dclk edges since reset release; cl/cr = words of the current frame.
    int            n[2];
    bit            held[2];
    bit            acc[2];
    bit            eu[2];
    logic [DW-1:0] hl[2], hr[2], cl[2], cr[2];
    int            ucnt[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input int k);
        logic          r, v;
        logic [DW-1:0] flip;
        r    = (k != 0) ? rst1 : rst0;
        v    = (k != 0) ? valid1 : valid0;
        flip = (k != 0) ? 18'h20000 : 18'h0;
        if (r) begin
            n[k] = 0; held[k] = 0; acc[k] = 0; eu[k] = 0;
            cl[k] = '0; cr[k] = '0; hl[k] = '0; hr[k] = '0;
        end else begin
            acc[k] = v && !held[k];
            n[k]++;
            eu[k] = 0;
            if (n[k] >= 8 && (n[k] - 8) % 512 == 0) begin
                if (held[k]) begin
                    cl[k] = hl[k]; cr[k] = hr[k]; held[k] = 0;
                end else begin
                    cl[k] = '0; cr[k] = '0; eu[k] = 1;
                end
            end
            if (acc[k]) begin
                held[k] = 1;
                hl[k]   = din_left ^ flip;
                hr[k]   = din_right ^ flip;
            end
        end
    endtask

    // Expected {bclk, lrclk, sdout, underrun, din_ready} after the latest edge.
    function automatic logic [4:0] expv(input int k);
        int            b, p;
        logic          lr, sd, bc;
        logic [DW-1:0] w;
        lr = 1'b0;
        sd = 1'b0;
        bc = ((n[k] / 4) % 2) != 0;
        if (n[k] >= 8) begin
            b  = ((n[k] - 8) / 8) % 64;
            p  = b % 32;
            lr = (b >= 32);
            w  = lr ? cr[k] : cl[k];
            if (p >= 1 && p <= DW) sd = w[DW-p];
        end
        return {bc, lr, sd, eu[k], ~held[k]};
    endfunction

    task automatic tick();
        logic [4:0] o0, o1;
        @(posedge dclk);
        model_step(0);
        model_step(1);
        #1;
        o0 = {bclk0, lrclk0, sdout0, under0, ready0};
        o1 = {bclk1, lrclk1, sdout1, under1, ready1};
        chk($sformatf("dut0 n=%0d {bclk,lrclk,sdout,underrun,ready}", n[0]), 32'(o0), 32'(expv(0)));
        chk($sformatf("dut1 n=%0d {bclk,lrclk,sdout,underrun,ready}", n[1]), 32'(o1), 32'(expv(1)));
        ucnt[0] += int'(under0);
        ucnt[1] += int'(under1);
    endtask

    task automatic run_to(input int k, input int target);
        for (int g = 0; g < 20000 && n[k] < target; g++) tick();
        if (n[k] < target) chk("run_to bound", 32'(n[k]), 32'(target));
    endtask

    task automatic wait_acc(input int k, input string tag);
        for (int g = 0; g < 2000; g++) begin
            tick();
            if (acc[k]) break;
        end
        if (!acc[k]) chk(tag, 32'(acc[k]), 32'd1);
    endtask

    initial begin
        int         pk;
        bit         found;
        logic [4:0] e;
        rst0 = 1'b1; rst1 = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
        din_left = '0; din_right = '0;
        ucnt[0] = 0; ucnt[1] = 0;
        repeat (3) tick();
        rst0 = 1'b0;

        // Single frame: pair accepted before the first frame start at edge 8.
        valid0 = 1'b1; din_left = 18'h2AAAA; din_right = 18'h15555;
        tick();
        valid0 = 1'b0;
        run_to(0, 500);

        // Three idle frames: one underrun pulse each.
        ucnt[0] = 0;
        run_to(0, 1550);
        chk("underrun pulses over 3 idle frames", 32'(ucnt[0]), 32'd3);

        // Backpressure: valid held high, pairs 1..4, one accepted per frame.
        ucnt[0] = 0;
        pk = 1;
        valid0 = 1'b1; din_left = 18'(pk); din_right = 18'(pk + 'h100);
        for (int g = 0; g < 3000 && pk <= 4; g++) begin
            tick();
            if (acc[0]) begin
                pk++;
                din_left = 18'(pk); din_right = 18'(pk + 'h100);
            end
        end
        valid0 = 1'b0;
        chk("backpressure pairs accepted", 32'(pk), 32'd5);
        run_to(0, 4100);
        chk("no underrun while backpressured", 32'(ucnt[0]), 32'd0);

        // Accept in the very frame-start cycle: no bypass.
        run_to(0, 4615);
        valid0 = 1'b1; din_left = 18'h00001; din_right = 18'h00001;
        tick();
        valid0 = 1'b0;
        chk("underrun on simultaneous accept", 32'(under0), 32'd1);
        run_to(0, 5650);

        // Random sparse traffic.
        for (int i = 0; i < 3072; i++) begin
            valid0    = ($urandom_range(0, 255) < 2);
            din_left  = 18'($urandom);
            din_right = 18'($urandom);
            tick();
        end
        valid0 = 1'b0;

        // Offset binary, then asynchronous reset with a pair still held.
        rst1 = 1'b0;
        valid1 = 1'b1; din_left = 18'h20000; din_right = 18'h00000;
        tick();
        din_left = 18'h3FFFF; din_right = 18'h3FFFF;
        wait_acc(1, "offset second accept");
        din_left = 18'h12345; din_right = 18'h0ABCD;
        wait_acc(1, "offset third accept");
        valid1 = 1'b0;
        found = 1'b0;
        for (int g = 0; g < 1200 && !found; g++) begin
            tick();
            e = expv(1);
            if (n[1] > 520 && held[1] && e[4] && !e[3] && e[2]) found = 1'b1;
        end
        chk("mid-frame reset point reached", 32'(found), 32'd1);
        #2 rst1 = 1'b1;
        #1 chk("async reset outputs", 32'({bclk1, lrclk1, sdout1, under1, ready1}), 32'b00001);
        tick();
        tick();
        rst1 = 1'b0;
        ucnt[1] = 0;
        run_to(1, 1040);
        chk("held pair discarded by reset", 32'(ucnt[1]), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
